// File: rtl/pow_job_queue.sv
`default_nettype none
// ============================================================================
// pow_job_queue : request FIFO and issue/return sequencer for the pow engine
// Rev 1.0
// ============================================================================
module pow_job_queue #(
  parameter int X     = 16,
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int T     = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [X-1:0]               i_in_x,
  input  logic [N-1:0]               i_in_n,
  input  logic [T-1:0]               i_in_tag,
  output logic                       o_eng_start,
  output logic [X-1:0]               o_eng_x,
  output logic [N-1:0]               o_eng_n,
  input  logic                       i_eng_ready,
  input  logic [X-1:0]               i_eng_out,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [X-1:0]               o_out_result,
  output logic [T-1:0]               o_out_tag,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [X-1:0]   r_mem_x [DEPTH];
  logic [N-1:0]   r_mem_n [DEPTH];
  logic [T-1:0]   r_mem_t [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [T-1:0]   r_cur_tag;
  logic           r_out_valid;
  logic [X-1:0]   r_out_result;
  logic [T-1:0]   r_out_tag;

  logic           w_push;
  logic           w_pop;

  // Ready looks only at occupancy, so a same-cycle pop never frees a slot.
  assign o_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = i_in_valid & o_in_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wptr] <= i_in_x;
      r_mem_n[r_wptr] <= i_in_n;
      r_mem_t[r_wptr] <= i_in_tag;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    o_eng_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && i_eng_ready) begin
          o_eng_start = 1'b1;
          w_pop       = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_eng_ready) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_cur_tag    <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) r_cur_tag <= r_mem_t[r_rptr];
      if ((r_state == S_WAIT) && i_eng_ready) begin
        r_out_result <= i_eng_out;
        r_out_tag    <= r_cur_tag;
        r_out_valid  <= 1'b1;
      end else if ((r_state == S_HOLD) && i_out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign o_eng_x      = r_mem_x[r_rptr];
  assign o_eng_n      = r_mem_n[r_rptr];
  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_out_result;
  assign o_out_tag    = r_out_tag;
  assign o_busy       = (r_state != S_IDLE) | (r_count != '0);
  assign o_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pow_job_queue.sv
`default_nettype none
// ============================================================================
// tb_pow_job_queue : randomized bench with engine model and in-order scoreboard
// Rev 1.0
// ============================================================================
module tb_pow_job_queue;

  localparam int X     = 16;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int T     = 4;

  logic          clk;
  logic          nrst;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [X-1:0]  i_in_x;
  logic [N-1:0]  i_in_n;
  logic [T-1:0]  i_in_tag;
  logic          o_eng_start;
  logic [X-1:0]  o_eng_x;
  logic [N-1:0]  o_eng_n;
  logic          i_eng_ready;
  logic [X-1:0]  i_eng_out;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [X-1:0]  o_out_result;
  logic [T-1:0]  o_out_tag;
  logic          o_busy;
  logic [2:0]    o_count;

  pow_job_queue #(.X(X), .N(N), .DEPTH(DEPTH), .T(T)) u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_x       (i_in_x),
    .i_in_n       (i_in_n),
    .i_in_tag     (i_in_tag),
    .o_eng_start  (o_eng_start),
    .o_eng_x      (o_eng_x),
    .o_eng_n      (o_eng_n),
    .i_eng_ready  (i_eng_ready),
    .i_eng_out    (i_eng_out),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_result (o_out_result),
    .o_out_tag    (o_out_tag),
    .o_busy       (o_busy),
    .o_count      (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [X-1:0] ref_pow(input logic [X-1:0] x, input logic [N-1:0] n);
    logic [X-1:0] r;
    r = 1;
    for (int i = 0; i < int'(n); i++) r = r * x;
    return r;
  endfunction

  // Scoreboard: every accepted job in order; issue and completion indices walk it.
  logic [X-1:0] q_x[$];
  logic [N-1:0] q_n[$];
  logic [T-1:0] q_t[$];
  int n_issue = 0;
  int n_done  = 0;
  int n_starts = 0;
  logic [X-1:0] last_res;
  logic [T-1:0] last_tag;
  logic pv, pr;
  logic [X-1:0] p_res;
  logic [T-1:0] p_tag;
  logic rnd_en = 1'b0;

  // Engine model: ready drops after a start, returns after a random latency.
  initial begin : g_engine
    logic st;
    logic [X-1:0] ex, res;
    logic [N-1:0] en;
    int cnt;
    i_eng_ready = 1'b1;
    i_eng_out   = '0;
    cnt = 0;
    res = '0;
    forever begin
      @(negedge clk);
      st = o_eng_start && nrst;
      ex = o_eng_x;
      en = o_eng_n;
      @(posedge clk);
      #1;
      if (!nrst) begin
        i_eng_ready = 1'b1;
        cnt = 0;
      end else if (st) begin
        i_eng_ready = 1'b0;
        cnt = $urandom_range(1, 4);
        res = ref_pow(ex, en);
      end else if (!i_eng_ready) begin
        cnt--;
        if (cnt == 0) begin
          i_eng_ready = 1'b1;
          i_eng_out   = res;
        end
      end
    end
  end

  initial begin : g_rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) i_out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin : g_monitor
    int outst;
    if (!nrst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      outst = q_x.size() - n_done;
      chk("busy", {31'd0, o_busy}, {31'd0, outst != 0});
      chk("count_max", {31'd0, o_count <= 3'(DEPTH)}, 32'd1);
      chk("in_ready", {31'd0, o_in_ready}, {31'd0, o_count < 3'(DEPTH)});
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, o_out_valid}, 32'd1);
        chk("hold_result", {16'd0, o_out_result}, {16'd0, p_res});
        chk("hold_tag", {28'd0, o_out_tag}, {28'd0, p_tag});
      end
      if (o_eng_start) begin
        n_starts++;
        if (n_issue < q_x.size()) begin
          chk("eng_x", {16'd0, o_eng_x}, {16'd0, q_x[n_issue]});
          chk("eng_n", {24'd0, o_eng_n}, {24'd0, q_n[n_issue]});
        end else begin
          chk("start_without_job", 32'd1, 32'd0);
        end
        n_issue++;
      end
      if (o_out_valid && i_out_ready) begin
        if (n_done < q_x.size()) begin
          chk("out_result", {16'd0, o_out_result}, {16'd0, ref_pow(q_x[n_done], q_n[n_done])});
          chk("out_tag", {28'd0, o_out_tag}, {28'd0, q_t[n_done]});
        end else begin
          chk("result_without_job", 32'd1, 32'd0);
        end
        last_res = o_out_result;
        last_tag = o_out_tag;
        n_done++;
      end
      if (i_in_valid && o_in_ready) begin
        q_x.push_back(i_in_x);
        q_n.push_back(i_in_n);
        q_t.push_back(i_in_tag);
      end
      pv = o_out_valid;
      pr = i_out_ready;
      p_res = o_out_result;
      p_tag = o_out_tag;
    end
  end

  // Called at posedge+1; returns at posedge+1 with i_in_valid low.
  task automatic push(input logic [X-1:0] x, input logic [N-1:0] n, input logic [T-1:0] tag,
                      input int maxc, output bit ok);
    i_in_valid = 1'b1;
    i_in_x = x;
    i_in_n = n;
    i_in_tag = tag;
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (o_in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(posedge clk);
      #1;
      if (n_done >= target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic [X-1:0] x, input logic [N-1:0] n, input logic [T-1:0] tag,
                         input logic [X-1:0] exp_res);
    bit ok;
    int tgt;
    tgt = n_done + 1;
    push(x, n, tag, 20, ok);
    chk("accept_one", {31'd0, ok}, 32'd1);
    wait_done(tgt, 50);
    chk("direct_result", {16'd0, last_res}, {16'd0, exp_res});
    chk("direct_tag", {28'd0, last_tag}, {28'd0, tag});
  endtask

  initial begin : g_main
    bit ok, seen, acc;
    int s0, tgt;
    nrst = 1'b0;
    i_in_valid = 1'b0;
    i_in_x = '0;
    i_in_n = '0;
    i_in_tag = '0;
    i_out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_count", {29'd0, o_count}, 32'd0);
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_eng_start", {31'd0, o_eng_start}, 32'd0);
    chk("rst_out_result", {16'd0, o_out_result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Single job with start-pulse count and busy return.
    s0 = n_starts;
    run_one(16'd3, 8'd5, 4'd2, 16'd243);
    chk("single_starts", n_starts - s0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("single_idle_busy", {31'd0, o_busy}, 32'd0);

    run_one(16'd7, 8'd0, 4'd1, 16'd1);
    run_one(16'd3, 8'd11, 4'd3, 16'd46075);
    run_one(16'd2, 8'd17, 4'd4, 16'd0);

    // Output stalled: 5 jobs fit, the 6th waits for the first handshake.
    i_out_ready = 1'b0;
    s0 = n_starts;
    tgt = n_done;
    for (int i = 0; i < 5; i++) begin
      push(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 20)), 4'(i), 20, ok);
      chk("stall_accept", {31'd0, ok}, 32'd1);
    end
    push(16'd9, 8'd2, 4'd5, 10, ok);
    chk("stall_sixth_refused", {31'd0, ok}, 32'd0);
    chk("stall_count", {29'd0, o_count}, 32'd4);
    chk("stall_starts", n_starts - s0, 32'd1);
    chk("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
    i_out_ready = 1'b1;
    push(16'd9, 8'd2, 4'd5, 30, ok);
    chk("stall_sixth_accept", {31'd0, ok}, 32'd1);
    wait_done(tgt + 6, 200);

    // Random burst with a toggling consumer.
    tgt = n_done + 4;
    rnd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 40)), 4'(i), 40, ok);
      chk("burst_accept", {31'd0, ok}, 32'd1);
    end
    wait_done(tgt, 400);
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    i_out_ready = 1'b1;

    // Full FIFO while the head is popped: push refused that cycle, taken the next.
    i_out_ready = 1'b0;
    tgt = n_done;
    for (int i = 0; i < 5; i++) begin
      push(16'($urandom_range(1, 300)), 8'($urandom_range(0, 9)), 4'(8 + i), 20, ok);
      chk("full_accept", {31'd0, ok}, 32'd1);
    end
    repeat (8) @(posedge clk);
    #1;
    chk("full_count", {29'd0, o_count}, 32'd4);
    i_in_valid = 1'b1;
    i_in_x = 16'd11;
    i_in_n = 8'd3;
    i_in_tag = 4'd13;
    i_out_ready = 1'b1;
    seen = 1'b0;
    acc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_eng_start && o_count == 3'd4) begin
        seen = 1'b1;
        chk("full_pop_ready", {31'd0, o_in_ready}, 32'd0);
      end
      if (o_in_ready) begin
        acc = 1'b1;
        chk("accept_after_pop", {31'd0, seen}, 32'd1);
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    i_in_valid = 1'b0;
    chk("full_sixth_accept", {31'd0, acc}, 32'd1);
    wait_done(tgt + 6, 200);

    // Reset while a job is in WAIT and two are queued.
    push(16'd4, 8'd4, 4'd1, 20, ok);
    push(16'd5, 8'd5, 4'd2, 20, ok);
    push(16'd6, 8'd6, 4'd3, 20, ok);
    chk("pre_rst_count", {29'd0, o_count}, 32'd2);
    #1;
    nrst = 1'b0;
    q_x.delete();
    q_n.delete();
    q_t.delete();
    n_issue = 0;
    n_done = 0;
    #1;
    chk("mid_rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("mid_rst_count", {29'd0, o_count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    chk("mid_rst_eng_start", {31'd0, o_eng_start}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    run_one(16'd5, 8'd3, 4'd6, 16'd125);
    repeat (3) @(posedge clk);
    #1;
    chk("final_busy", {31'd0, o_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : g_watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
